vga_scan_controller: RTL and testbench

Raster timing and pixel-fetch stage that sits directly upstream of the MiniAlu VGA outputs. It divides the system clock into a pixel tick and runs horizontal/vertical counters for 640x480 at 60 Hz. It issues one read per visible pixel to the video RAM and drives oVGA_R/G/B plus both sync lines, with colour and sync aligned to the same pixel. The MiniAlu writes the video RAM; this block only reads it.

---
 rtl/vga_scan_controller.sv | 217 +++++++++++++++++++++
 tb/tb_vga_scan_controller.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_controller.sv
// 640x480@60 raster timing and video-RAM pixel fetch for the MiniAlu VGA path.
// Define VGA_TEST_PATTERN_EN to replace the RAM fetch with 8 vertical colour bars.
module vga_scan_controller #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter int CLK_DIV   = 2
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [2:0] iPixel,
   output logic       oReadEnable,
   output logic [9:0] oColumn,
   output logic [9:0] oRow,
   output logic       oVGA_R,
   output logic       oVGA_G,
   output logic       oVGA_B,
   output logic       oHorizontal_Sync,
   output logic       oVertical_Sync,
   output logic       oFrameStart
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS_L  = 10'(H_VISIBLE);
   localparam logic [9:0] H_SYN_L  = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] H_BCK_L  = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] V_VIS_L  = 10'(V_VISIBLE);
   localparam logic [9:0] V_SYN_L  = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] V_BCK_L  = 10'(V_VISIBLE + V_FRONT + V_SYNC);

   localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   // Segment of the scan a counter is currently in; porches must be non-zero.
   typedef enum logic [1:0] {
      S_VISIBLE,
      S_FRONT,
      S_SYNC,
      S_BACK
   } seg_t;

   logic [DIV_W-1:0] r_div;
   logic             w_tick;

   logic [9:0] r_hcount;
   logic [9:0] r_vcount;
   logic [9:0] w_h_next;
   logic [9:0] w_v_next;
   logic       w_h_last;
   logic       w_v_last;
   seg_t       r_hstate;
   seg_t       r_vstate;

   logic       w_vis;
   logic       w_hs;
   logic       w_vs;
   logic       w_origin;

   logic       r_d_vis;
   logic       r_d_hs;
   logic       r_d_vs;
   logic       r_d_first;
   logic [2:0] r_pixel;

   assign w_tick   = (r_div == DIV_LAST);
   assign w_h_last = (r_hcount == H_LAST);
   assign w_v_last = (r_vcount == V_LAST);

   // Counters hold the position fetched on the next tick.
   assign w_vis    = (r_hstate == S_VISIBLE) && (r_vstate == S_VISIBLE);
   assign w_hs     = (r_hstate != S_SYNC);
   assign w_vs     = (r_vstate != S_SYNC);
   assign w_origin = (r_hcount == 10'd0) && (r_vcount == 10'd0);

   // Raster position that follows the current one.
   always_comb begin
      w_h_next = r_hcount + 10'd1;
      w_v_next = r_vcount;
      if (w_h_last) begin
         w_h_next = 10'd0;
         w_v_next = w_v_last ? 10'd0 : r_vcount + 10'd1;
      end
   end

   // Pixel-tick divider: one tick every CLK_DIV system clocks.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         r_div <= '0;
      end else if (w_tick) begin
         r_div <= '0;
      end else begin
         r_div <= r_div + 1'b1;
      end
   end

   // Horizontal counter and its line-segment state machine.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         r_hcount <= 10'd0;
         r_hstate <= S_VISIBLE;
      end else if (w_tick) begin
         r_hcount <= w_h_next;
         unique case (r_hstate)
            S_VISIBLE: if (w_h_next == H_VIS_L) r_hstate <= S_FRONT;
            S_FRONT:   if (w_h_next == H_SYN_L) r_hstate <= S_SYNC;
            S_SYNC:    if (w_h_next == H_BCK_L) r_hstate <= S_BACK;
            S_BACK:    if (w_h_next == 10'd0)   r_hstate <= S_VISIBLE;
            default:   r_hstate <= S_VISIBLE;
         endcase
      end
   end

   // Vertical counter and its frame-segment state machine, stepped at line end.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         r_vcount <= 10'd0;
         r_vstate <= S_VISIBLE;
      end else if (w_tick && w_h_last) begin
         r_vcount <= w_v_next;
         unique case (r_vstate)
            S_VISIBLE: if (w_v_next == V_VIS_L) r_vstate <= S_FRONT;
            S_FRONT:   if (w_v_next == V_SYN_L) r_vstate <= S_SYNC;
            S_SYNC:    if (w_v_next == V_BCK_L) r_vstate <= S_BACK;
            S_BACK:    if (w_v_next == 10'd0)   r_vstate <= S_VISIBLE;
            default:   r_vstate <= S_VISIBLE;
         endcase
      end
   end

   // Fetch stage: read strobe plus the timing attributes that travel with it.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         oReadEnable <= 1'b0;
         oColumn     <= 10'd0;
         oRow        <= 10'd0;
         r_d_vis     <= 1'b0;
         r_d_hs      <= 1'b1;
         r_d_vs      <= 1'b1;
         r_d_first   <= 1'b0;
      end else begin
         oReadEnable <= 1'b0;
         if (w_tick) begin
            r_d_vis   <= w_vis;
            r_d_hs    <= w_hs;
            r_d_vs    <= w_vs;
            r_d_first <= w_origin;
            if (w_vis) begin
               oColumn <= r_hcount;
               oRow    <= r_vcount;
`ifndef VGA_TEST_PATTERN_EN
               oReadEnable <= 1'b1;
`endif
            end
         end
      end
   end

`ifdef VGA_TEST_PATTERN_EN
   // Bar index is column / 80, done with compares instead of a divider.
   function automatic logic [2:0] f_bar(input logic [9:0] h);
      logic [2:0] b;
      b = 3'd0;
      for (int i = 1; i < 8; i++) begin
         if (h >= 10'(i * 80)) b = 3'(i);
      end
      return b;
   endfunction

   // Pattern source: bar colour loaded at fetch time, same slot as RAM data.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         r_pixel <= 3'd0;
      end else if (w_tick && w_vis) begin
         r_pixel <= f_bar(r_hcount);
      end
   end
`else
   // Capture RAM data one clock after the read strobe.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         r_pixel <= 3'd0;
      end else if (oReadEnable) begin
         r_pixel <= iPixel;
      end
   end
`endif

   // Output stage: colour and sync for the same pixel land on one tick.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         oVGA_R           <= 1'b0;
         oVGA_G           <= 1'b0;
         oVGA_B           <= 1'b0;
         oHorizontal_Sync <= 1'b1;
         oVertical_Sync   <= 1'b1;
         oFrameStart      <= 1'b0;
      end else begin
         oFrameStart <= 1'b0;
         if (w_tick) begin
            {oVGA_R, oVGA_G, oVGA_B} <= r_d_vis ? r_pixel : 3'b000;
            oHorizontal_Sync         <= r_d_hs;
            oVertical_Sync           <= r_d_vs;
            oFrameStart              <= r_d_first;
         end
      end
   end

endmodule

// File: tb/tb_vga_scan_controller.sv
// Scoreboard bench for vga_scan_controller with a short vertical frame.
// Expected raster values are derived from tick counts since reset release.
module tb_vga_scan_controller;

   localparam int HV = 640;
   localparam int HF = 16;
   localparam int HS = 96;
   localparam int HB = 48;
   localparam int HT = HV + HF + HS + HB;
   localparam int VV = 11;
   localparam int VF = 1;
   localparam int VS = 2;
   localparam int VB = 1;
   localparam int VT = VV + VF + VS + VB;
   localparam int D  = 2;
   localparam int FRAME = HT * VT * D;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] px = 3'b111;

   logic       oReadEnable;
   logic [9:0] oColumn;
   logic [9:0] oRow;
   logic       oVGA_R;
   logic       oVGA_G;
   logic       oVGA_B;
   logic       oHorizontal_Sync;
   logic       oVertical_Sync;
   logic       oFrameStart;

   int checks = 0;
   int failures = 0;
   int e = 0;
   int clk_n = 0;
   int rd_idx = 0;
   bit pat_col = 1'b1;
   logic [2:0] sb[$];
   logic [2:0] exp_rgb = 3'd0;

   int   hs_lo = 0;
   int   vs_lo = 0;
   int   last_fs = -1;
   int   fs_at = -1;
   logic hs_prev = 1'b1;
   logic vs_prev = 1'b1;

   vga_scan_controller #(
      .H_VISIBLE (HV),
      .H_FRONT   (HF),
      .H_SYNC    (HS),
      .H_BACK    (HB),
      .V_VISIBLE (VV),
      .V_FRONT   (VF),
      .V_SYNC    (VS),
      .V_BACK    (VB),
      .CLK_DIV   (D)
   ) dut (
      .Clock            (clk),
      .Reset            (rst_n),
      .iPixel           (px),
      .oReadEnable      (oReadEnable),
      .oColumn          (oColumn),
      .oRow             (oRow),
      .oVGA_R           (oVGA_R),
      .oVGA_G           (oVGA_G),
      .oVGA_B           (oVGA_B),
      .oHorizontal_Sync (oHorizontal_Sync),
      .oVertical_Sync   (oVertical_Sync),
      .oFrameStart      (oFrameStart)
   );

   always #5 clk = ~clk;

   // Clocks since reset release, and absolute clock count.
   always @(posedge clk) begin
      e     <= rst_n ? e + 1 : 0;
      clk_n <= clk_n + 1;
   end

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at clk %0d",
                  nm, act, exp, clk_n);
      end
   endtask

   // RAM model: answers each read one clock later and queues the answer.
   always @(negedge clk) begin
      logic [2:0] v;
      if (!rst_n) begin
         rd_idx = 0;
         px = 3'b111;
      end else begin
         px = 3'b111;
         if (oReadEnable === 1'b1) begin
            check("rd_col", 32'(oColumn), rd_idx % HV);
            check("rd_row", 32'(oRow), (rd_idx / HV) % VV);
            v = pat_col ? 3'((rd_idx % HV) % 8) : 3'($urandom);
            px = v;
            sb.push_back(v);
            rd_idx++;
         end
      end
   end

   // Monitor: raster model per clock, colour popped from the scoreboard.
   always @(negedge clk) begin
      int k, q, h, v, p;
      logic ehs, evs, efs, ere;
      logic [6:0] expv, actv;
      k = e / D;
      ere = 1'b0;
      if (e >= D && e % D == 0) begin
         p = k - 1;
         h = p % HT;
         v = (p / HT) % VT;
         ere = (h < HV) && (v < VV);
      end
`ifdef VGA_TEST_PATTERN_EN
      ere = 1'b0;
`endif
      ehs = 1'b1;
      evs = 1'b1;
      efs = 1'b0;
      if (e < 2 * D) begin
         exp_rgb = 3'd0;
      end else begin
         q = k - 2;
         h = q % HT;
         v = (q / HT) % VT;
         ehs = !(h >= HV + HF && h < HV + HF + HS);
         evs = !(v >= VV + VF && v < VV + VF + VS);
         if (e % D == 0) begin
            efs = (h == 0) && (v == 0);
            if (h < HV && v < VV) begin
`ifdef VGA_TEST_PATTERN_EN
               exp_rgb = 3'(h / 80);
               if (v == 10 && h == 85)
                  check("tp_px85", {oVGA_R, oVGA_G, oVGA_B}, 3'b001);
               if (v == 10 && h == 639)
                  check("tp_px639", {oVGA_R, oVGA_G, oVGA_B}, 3'b111);
`else
               if (sb.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL sb_empty: got no queued pixel for (%0d,%0d)",
                           h, v);
                  exp_rgb = 3'd0;
               end else begin
                  exp_rgb = sb.pop_front();
               end
`endif
            end else begin
               exp_rgb = 3'd0;
            end
         end
      end
      expv = {ere, ehs, evs, exp_rgb, efs};
      actv = {oReadEnable, oHorizontal_Sync, oVertical_Sync,
              oVGA_R, oVGA_G, oVGA_B, oFrameStart};
      check("outputs", 32'(actv), 32'(expv));
      if (e == 0) begin
         check("rst_col", 32'(oColumn), 0);
         check("rst_row", 32'(oRow), 0);
      end
   end

   // Pulse-width and period measurements on the sync outputs.
   always @(negedge clk) begin
      if (!rst_n) begin
         hs_lo = 0;
         vs_lo = 0;
         last_fs = -1;
         fs_at = -1;
         hs_prev = 1'b1;
         vs_prev = 1'b1;
      end else begin
         if (oFrameStart === 1'b1) begin
            if (last_fs >= 0) check("frame_period", clk_n - last_fs, FRAME);
            last_fs = clk_n;
            fs_at = clk_n;
         end
         if (oHorizontal_Sync === 1'b0) begin
            if (hs_prev && fs_at >= 0) begin
               check("hs_fall_after_fs", clk_n - fs_at, (HV + HF) * D);
               fs_at = -1;
            end
            hs_lo++;
         end else if (hs_lo > 0) begin
            check("hs_low_width", hs_lo, HS * D);
            hs_lo = 0;
         end
         hs_prev = oHorizontal_Sync;
         if (oVertical_Sync === 1'b0) begin
            vs_lo++;
         end else if (vs_lo > 0) begin
            check("vs_low_width", vs_lo, VS * HT * D);
            vs_lo = 0;
         end
         vs_prev = oVertical_Sync;
      end
   end

   initial begin
      int n;
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      // Stop inside frame 2 with the counters at h=300, v=2.
      repeat (FRAME + (2 * HT + 300) * D + 1) @(negedge clk);
      rst_n = 1'b0;
      n = $urandom_range(4, 1);
      @(negedge clk);
      sb.delete();
      repeat (n - 1) @(negedge clk);
      pat_col = 1'b0;
      rst_n = 1'b1;
      repeat (FRAME + 4 * HT * D) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
